// File: rtl/instruction_issuer_pkg.sv
// instruction_issuer_pkg: shared accelerator constants, instruction layout and opcode check.
package instruction_issuer_pkg;

    localparam int INSTRUCTION_WIDTH = 32;

    localparam int OPC_LSB  = 0;
    localparam int FUNC_LSB = 8;
    localparam int BUF_LSB  = 12;
    localparam int MEM_LSB  = 16;

    localparam logic [7:0] OP_REG_LOAD    = 8'h01;
    localparam logic [7:0] OP_WEIGHT_LOAD = 8'h02;
    localparam logic [7:0] OP_COMPUTE     = 8'h04;
    localparam logic [7:0] OP_DRAIN       = 8'h08;
    localparam logic [7:0] OP_STORE       = 8'h10;

    typedef struct packed {
        logic [15:0] mem_addr;
        logic [3:0]  buf_addr;
        logic [3:0]  func;
        logic [7:0]  opcode;
    } instr_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return op inside {OP_REG_LOAD, OP_WEIGHT_LOAD, OP_COMPUTE, OP_DRAIN, OP_STORE};
    endfunction

endpackage

// File: rtl/instruction_issuer_prog_mem.sv
// instr_prog_mem: program store with one synchronous write port and an asynchronous read port.
module instr_prog_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_issuer.sv
// instruction_issuer: replays a stored program for several passes into an instruction FIFO,
// offsetting the memory-address field by a stride each pass and rejecting illegal opcodes.
module instruction_issuer #(
    parameter int INSTRUCTION_WIDTH = instruction_issuer_pkg::INSTRUCTION_WIDTH,
    parameter int PROG_DEPTH        = 16,
    parameter int LOOP_W            = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          prog_we,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
    input  logic [INSTRUCTION_WIDTH-1:0]  prog_data,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(PROG_DEPTH):0]   prog_len,
    input  logic [LOOP_W-1:0]             loop_count,
    input  logic [15:0]                   addr_stride,
    output logic [INSTRUCTION_WIDTH-1:0]  instruction,
    output logic                          instruction_valid,
    input  logic                          instruction_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [15:0]                   issued_count
);

    import instruction_issuer_pkg::*;

    localparam int AW = $clog2(PROG_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [AW-1:0]                pc_q, pc_d, nxt_pc, rd_addr;
    logic [AW:0]                  len_q, len_d;
    logic [LOOP_W-1:0]            loops_q, loops_d, iter_q, iter_d, nxt_iter, eff_loops;
    logic [15:0]                  stride_q, stride_d, off_q, off_d, nxt_off, ld_off;
    logic [15:0]                  issued_q, issued_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d, rd_data, word;
    logic                         valid_q, valid_d, err_q, err_d;
    logic                         xfer, wrap, last, legal;

    instr_prog_mem #(
        .WIDTH (INSTRUCTION_WIDTH),
        .DEPTH (PROG_DEPTH)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (prog_we && state_q == S_IDLE),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign xfer      = valid_q && instruction_ready;
    assign wrap      = {1'b0, pc_q} == len_q - 1'b1;
    assign eff_loops = loops_q == '0 ? LOOP_W'(1) : loops_q;
    assign last      = wrap && iter_q == eff_loops - 1'b1;
    assign nxt_pc    = wrap ? '0 : pc_q + 1'b1;
    assign nxt_iter  = wrap ? iter_q + 1'b1 : iter_q;
    assign nxt_off   = wrap ? off_q + stride_q : off_q;

    // The read port always points at the entry that would be loaded on this cycle's edge.
    assign rd_addr = state_q == S_ISSUE ? nxt_pc : '0;
    assign ld_off  = state_q == S_ISSUE ? nxt_off : '0;

    always_comb begin
        word = rd_data;
        word[MEM_LSB +: 16] = rd_data[MEM_LSB +: 16] + ld_off;
        legal = is_legal_op(rd_data[OPC_LSB +: 8]);
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        loops_d  = loops_q;
        iter_d   = iter_q;
        stride_d = stride_q;
        off_d    = off_q;
        issued_d = issued_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                len_d    = prog_len;
                loops_d  = loop_count;
                stride_d = addr_stride;
                pc_d     = '0;
                iter_d   = '0;
                off_d    = '0;
                issued_d = '0;
                err_d    = 1'b0;
                if (prog_len == '0) state_d = S_DONE;
                else if (legal) begin
                    instr_d = word;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_ISSUE: begin
                if (xfer) issued_d = issued_q == 16'hFFFF ? issued_q : issued_q + 1'b1;
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (last) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        pc_d   = nxt_pc;
                        iter_d = nxt_iter;
                        off_d  = nxt_off;
                        if (legal) instr_d = word;
                        else begin
                            valid_d = 1'b0;
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            loops_q  <= '0;
            iter_q   <= '0;
            stride_q <= '0;
            off_q    <= '0;
            issued_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            loops_q  <= loops_d;
            iter_q   <= iter_d;
            stride_q <= stride_d;
            off_q    <= off_d;
            issued_q <= issued_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign instruction       = instr_q;
    assign instruction_valid = valid_q;
    assign busy              = state_q == S_ISSUE || state_q == S_DONE;
    assign done              = state_q == S_DONE;
    assign error             = err_q;
    assign issued_count      = issued_q;

endmodule

// File: doc/instruction_issuer.md
INSTRUCTION_ISSUER -- requirements
Module: instruction_issuer

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 32, meaning the instruction word width.
REQ-002 SHALL have parameter PROG_DEPTH, default 16, meaning the number of program-memory entries.
REQ-003 SHALL have parameter LOOP_W, default 8, meaning the loop-counter width.
REQ-004 SHALL have port clk, input, 1, the clock; rising edge only.
REQ-005 SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-006 SHALL have port prog_we, input, 1, the program-memory write strobe.
REQ-007 SHALL have port prog_addr, input, $clog2(PROG_DEPTH), the program write address.
REQ-008 SHALL have port prog_data, input, INSTRUCTION_WIDTH, the program write data.
REQ-009 SHALL have port start, input, 1, which launches a run.
REQ-010 SHALL have port abort, input, 1, which terminates a run.
REQ-011 SHALL have port prog_len, input, $clog2(PROG_DEPTH)+1, the number of instructions per pass (0..PROG_DEPTH).
REQ-012 SHALL have port loop_count, input, LOOP_W, the number of passes; 0 is treated as 1.
REQ-013 SHALL have port addr_stride, input, 16, the memory-address increment per pass.
REQ-014 SHALL have port instruction, output, INSTRUCTION_WIDTH, the word to the instruction FIFO.
REQ-015 SHALL have port instruction_valid, output, 1, meaning instruction holds a valid word.
REQ-016 SHALL have port instruction_ready, input, 1, driven as FIFO not-full.
REQ-017 SHALL have outputs busy (1), done (1, pulse), error (1, sticky), issued_count (16).

Function
REQ-018 Instruction fields SHALL be [7:0] opcode one-hot in {1,2,4,8,16}, [11:8] function, [15:12] buffer address, [31:16] memory address.
REQ-019 FSM states SHALL be IDLE, ISSUE, DONE and ERR.
REQ-020 In IDLE, start SHALL latch prog_len, loop_count and addr_stride, clear pc, iteration and offset, and clear error and issued_count.
REQ-021 start with prog_len≠0 SHALL load prog[0] into the output register and enter ISSUE; instruction_valid=1 the cycle after start.
REQ-022 start with prog_len=0 SHALL go to DONE, issue nothing, and pulse done the cycle after start.
REQ-023 Memory-address field out SHALL equal prog[pc][31:16] + offset, modulo 2^16; all other fields SHALL be copied unchanged.
REQ-024 A transfer SHALL occur only on a cycle with instruction_valid && instruction_ready.
REQ-025 While valid && !ready, instruction and instruction_valid SHALL hold stable.
REQ-026 Valid SHALL never drop without a transfer, except on abort or reset.
REQ-027 On transfer, the next entry SHALL load in the same cycle, so ready held high gives one instruction per cycle.
REQ-028 On transfer, issued_count SHALL increment, saturating at 0xFFFF.
REQ-029 On transfer with pc = latched_len-1, pc SHALL wrap to 0, iteration SHALL increment, and offset += stride (wraps at 2^16).
REQ-030 On transfer of the last word of the last pass, instruction_valid SHALL be 0 next cycle and the FSM SHALL enter DONE.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 Before presenting any entry, its opcode SHALL be checked against REQ-018.
REQ-033 An illegal opcode SHALL not be presented; the FSM SHALL enter ERR, set error=1 and keep valid=0.
REQ-034 ERR SHALL return to IDLE the next cycle with no done pulse; error SHALL remain set until the next accepted start.
REQ-035 busy SHALL be 1 in ISSUE and DONE.
REQ-036 start while busy SHALL be ignored.
REQ-037 prog_we while busy SHALL be ignored; in IDLE it SHALL write prog[prog_addr] at the clock edge.
REQ-038 abort in ISSUE SHALL return the FSM to IDLE with valid=0 next cycle and no done pulse; abort simultaneous with a transfer SHALL count that transfer.
REQ-039 abort SHALL take priority over start in the same cycle.

Reset
REQ-040 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE and instruction_valid, done, busy and error SHALL be 0.
REQ-041 While rst_n=0 at a clock edge, instruction and issued_count SHALL be 0; program memory contents SHALL be undefined.
REQ-042 Reset mid-run SHALL drop valid at the next edge with no done pulse.

Structure
REQ-043 INSTRUCTION_WIDTH, the opcode encodings (OP_REG_LOAD=1, OP_WEIGHT_LOAD=2, OP_COMPUTE=4, OP_DRAIN=8, OP_STORE=16) and the field offsets SHALL live in the shared accelerator package.
REQ-044 The package SHALL also hold a packed instruction struct typedef.
REQ-045 Program memory SHALL be a single sub-module, instr_prog_mem: 1 write port, asynchronous read.
REQ-046 The FSM, counters and output register SHALL reside in the top module.

Verification
REQ-047 Load 3 entries (opcodes 1,2,4; mem addr 0x0010), len=3, loops=2, stride=0x0100, ready=1 -> 6 back-to-back words, addresses 0x0010 ×3 then 0x0110 ×3; done one cycle after the 6th; issued_count=6.
REQ-048 Same program with ready low for 4 cycles mid-word 2 -> word held bit-stable with valid=1; no loss or duplication; total 6.
REQ-049 Entry 1 opcode=0x03 -> word 0 issued, then valid=0, error=1, no done, issued_count=1.
REQ-050 len=0 start -> done pulse next cycle, valid never asserted.
REQ-051 abort during stall after 2 transfers -> valid=0 next cycle, IDLE, no done, issued_count=2; a new start works normally.
REQ-052 stride=0xFFF0, base addr=0x0020, 2 loops -> second-pass address 0x0010 (wrap).
